// File: rtl/cme_count_pkg.sv
// Shared types and widths for the cascaded count-word generator/checker pair.
package cme_count_pkg;

    localparam int NIBBLE_W         = 4;
    localparam int WORD_W           = 8;
    localparam int DEFAULT_CARRY_AT = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/count_next_word.sv
// Combinational predictor of the successor of a {hi,lo} count word.
module count_next_word
    import cme_count_pkg::*;
#(
    parameter int CARRY_AT = DEFAULT_CARRY_AT
) (
    input  logic [WORD_W-1:0] i_word,
    output logic [WORD_W-1:0] o_next
);

    localparam logic [NIBBLE_W-1:0] CARRY_NIB = NIBBLE_W'(CARRY_AT);

    logic [NIBBLE_W-1:0] w_lo;
    logic [NIBBLE_W-1:0] w_hi;

    assign w_lo = i_word[NIBBLE_W-1:0];
    assign w_hi = i_word[WORD_W-1:NIBBLE_W];

    // Both nibbles wrap modulo 16; hi advances only on the carry value of lo.
    always_comb begin
        o_next                      = '0;
        o_next[NIBBLE_W-1:0]        = w_lo + 4'd1;
        o_next[WORD_W-1:NIBBLE_W]   = (w_lo == CARRY_NIB) ? (w_hi + 4'd1) : w_hi;
    end

endmodule

// File: rtl/count_stream_checker.sv
// Tracks the cascaded count stream: locks after a run of correct words, flags and counts breaks.
module count_stream_checker
    import cme_count_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int CARRY_AT   = DEFAULT_CARRY_AT,
    parameter int ERR_W      = 8
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              restart,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_word,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count,
    output logic [WORD_W-1:0] expected
);

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_COUNT);

    state_t             r_state;
    logic [3:0]         r_good_run;
    logic               r_locked;
    logic               r_err_pulse;
    logic [ERR_W-1:0]   r_err_count;
    logic [WORD_W-1:0]  r_expected;

    logic [WORD_W-1:0]  w_next;
    logic               w_match;
    logic [3:0]         w_run_inc;

    count_next_word #(
        .CARRY_AT (CARRY_AT)
    ) u_next (
        .i_word (in_word),
        .o_next (w_next)
    );

    assign w_match   = (in_word == r_expected);
    assign w_run_inc = r_good_run + 4'd1;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state     <= ST_IDLE;
            r_good_run  <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
            r_expected  <= '0;
        end else if (restart) begin
            r_state     <= ST_IDLE;
            r_good_run  <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
            r_expected  <= '0;
        end else if (in_valid) begin
            // Every accepted word reseeds the prediction, matching or not.
            r_expected  <= w_next;
            r_err_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_SYNC;
                    r_good_run <= 4'd1;
                end
                ST_SYNC: begin
                    if (w_match) begin
                        r_good_run <= w_run_inc;
                        if (w_run_inc == LOCK_RUN) begin
                            r_state  <= ST_LOCKED;
                            r_locked <= 1'b1;
                        end
                    end else begin
                        r_good_run <= 4'd1;
                    end
                end
                ST_LOCKED: begin
                    if (!w_match) begin
                        r_state     <= ST_SYNC;
                        r_locked    <= 1'b0;
                        r_good_run  <= 4'd1;
                        r_err_pulse <= 1'b1;
                        if (r_err_count != '1) begin
                            r_err_count <= r_err_count + ERR_W'(1);
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_good_run <= '0;
                    r_locked   <= 1'b0;
                end
            endcase
        end else begin
            r_err_pulse <= 1'b0;
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign expected  = r_expected;

endmodule

// File: tb/tb_count_stream_checker.sv
// Self-checking bench for count_stream_checker: vector table, corner sequences, random stream vs model.
module tb_count_stream_checker;

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic       restart = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_word = '0;

    logic       locked_a, pulse_a, locked_b, pulse_b;
    logic [7:0] cnt_a, exp_a, exp_b;
    logic [1:0] cnt_b;

    int errors = 0;
    int checks = 0;

    count_stream_checker #(.LOCK_COUNT(4), .CARRY_AT(7), .ERR_W(8)) dut_a (
        .clk(clk), .clear_n(clear_n), .restart(restart), .in_valid(in_valid),
        .in_word(in_word), .locked(locked_a), .err_pulse(pulse_a),
        .err_count(cnt_a), .expected(exp_a)
    );

    count_stream_checker #(.LOCK_COUNT(4), .CARRY_AT(7), .ERR_W(2)) dut_b (
        .clk(clk), .clear_n(clear_n), .restart(restart), .in_valid(in_valid),
        .in_word(in_word), .locked(locked_b), .err_pulse(pulse_b),
        .err_count(cnt_b), .expected(exp_b)
    );

    always #5 clk = ~clk;

    // Reference model: plain arithmetic on the sequence rule.
    bit         m_locked;
    bit         m_pulse;
    int         m_run;      // 0 means no word seen since reset/restart
    logic [7:0] m_exp;
    int         m_errs;

    function automatic logic [7:0] nxt(input logic [7:0] w);
        int lo, hi;
        lo = int'(w) % 16;
        hi = int'(w) / 16;
        if (lo == 7) hi = (hi + 1) % 16;
        lo = (lo + 1) % 16;
        return 8'(hi * 16 + lo);
    endfunction

    task automatic model_clear();
        m_locked = 0; m_pulse = 0; m_run = 0; m_exp = '0; m_errs = 0;
    endtask

    task automatic model_step(input bit r, input bit v, input logic [7:0] w);
        if (r) begin
            model_clear();
        end else if (v) begin
            m_pulse = 0;
            if (m_run == 0) begin
                m_run = 1;
            end else if (w == m_exp) begin
                if (!m_locked) begin
                    m_run++;
                    if (m_run == 4) m_locked = 1;
                end
            end else begin
                if (m_locked) begin
                    m_pulse = 1;
                    m_errs++;
                    m_locked = 0;
                end
                m_run = 1;
            end
            m_exp = nxt(w);
        end else begin
            m_pulse = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".locked_a"}, int'(locked_a), int'(m_locked));
        chk({tag, ".pulse_a"},  int'(pulse_a),  int'(m_pulse));
        chk({tag, ".cnt_a"},    int'(cnt_a),    (m_errs > 255) ? 255 : m_errs);
        chk({tag, ".exp_a"},    int'(exp_a),    int'(m_exp));
        chk({tag, ".locked_b"}, int'(locked_b), int'(m_locked));
        chk({tag, ".pulse_b"},  int'(pulse_b),  int'(m_pulse));
        chk({tag, ".cnt_b"},    int'(cnt_b),    (m_errs > 3) ? 3 : m_errs);
        chk({tag, ".exp_b"},    int'(exp_b),    int'(m_exp));
    endtask

    task automatic cycle(input bit r, input bit v, input logic [7:0] w, input string tag);
        restart = r; in_valid = v; in_word = w;
        @(posedge clk);
        model_step(r, v, w);
        #1;
        compare_model(tag);
    endtask

    task automatic lock_from(input logic [7:0] start);
        logic [7:0] w;
        w = start;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, w, "lock");
            w = nxt(w);
        end
    endtask

    typedef struct {
        bit         r;
        bit         v;
        logic [7:0] w;
        bit         locked;
        bit         pulse;
        int         cnt;
        logic [7:0] expw;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit r, bit v, logic [7:0] w, bit l, bit p, int c, logic [7:0] e);
        vec_t x;
        x.r = r; x.v = v; x.w = w; x.locked = l; x.pulse = p; x.cnt = c; x.expw = e;
        return x;
    endfunction

    initial begin
        int exp5[5];
        int pulses;
        logic [7:0] w;

        exp5 = '{1, 2, 3, 3, 3};

        // Lock from zero, carry-missing error, relock, then the two wrap cases.
        vt.push_back(mk(0,1,8'h00,0,0,0,8'h01));
        vt.push_back(mk(0,1,8'h01,0,0,0,8'h02));
        vt.push_back(mk(0,1,8'h02,0,0,0,8'h03));
        vt.push_back(mk(0,1,8'h03,1,0,0,8'h04));
        vt.push_back(mk(0,1,8'h04,1,0,0,8'h05));
        vt.push_back(mk(0,1,8'h05,1,0,0,8'h06));
        vt.push_back(mk(0,1,8'h06,1,0,0,8'h07));
        vt.push_back(mk(0,1,8'h07,1,0,0,8'h18));
        vt.push_back(mk(0,1,8'h08,0,1,1,8'h09));
        vt.push_back(mk(0,1,8'h09,0,0,1,8'h0A));
        vt.push_back(mk(0,1,8'h0A,0,0,1,8'h0B));
        vt.push_back(mk(0,1,8'h0B,1,0,1,8'h0C));
        vt.push_back(mk(1,1,8'h55,0,0,0,8'h00));
        vt.push_back(mk(0,1,8'hF4,0,0,0,8'hF5));
        vt.push_back(mk(0,1,8'hF5,0,0,0,8'hF6));
        vt.push_back(mk(0,1,8'hF6,0,0,0,8'hF7));
        vt.push_back(mk(0,1,8'hF7,1,0,0,8'h08));
        vt.push_back(mk(0,1,8'h08,1,0,0,8'h09));
        vt.push_back(mk(0,1,8'h09,1,0,0,8'h0A));
        vt.push_back(mk(1,0,8'h00,0,0,0,8'h00));
        vt.push_back(mk(0,1,8'h1C,0,0,0,8'h1D));
        vt.push_back(mk(0,1,8'h1D,0,0,0,8'h1E));
        vt.push_back(mk(0,1,8'h1E,0,0,0,8'h1F));
        vt.push_back(mk(0,1,8'h1F,1,0,0,8'h10));
        vt.push_back(mk(0,1,8'h10,1,0,0,8'h11));
        vt.push_back(mk(0,1,8'h11,1,0,0,8'h12));

        model_clear();
        #12;
        chk("reset.locked", int'(locked_a), 0);
        chk("reset.pulse",  int'(pulse_a),  0);
        chk("reset.cnt",    int'(cnt_a),    0);
        chk("reset.exp",    int'(exp_a),    0);
        @(negedge clk);
        clear_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vt[i]) begin
            cycle(vt[i].r, vt[i].v, vt[i].w, "vec");
            chk($sformatf("vec%0d.locked", i), int'(locked_a), int'(vt[i].locked));
            chk($sformatf("vec%0d.pulse", i),  int'(pulse_a),  int'(vt[i].pulse));
            chk($sformatf("vec%0d.cnt", i),    int'(cnt_a),    vt[i].cnt);
            chk($sformatf("vec%0d.cnt_b", i),  int'(cnt_b),    vt[i].cnt);
            chk($sformatf("vec%0d.exp", i),    int'(exp_a),    int'(vt[i].expw));
        end

        // Idle gap while locked holds everything.
        cycle(1, 0, 8'h00, "t4");
        lock_from(8'h21);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 8'hAA, "t4gap");
            chk("t4.gap_locked", int'(locked_a), 1);
            chk("t4.gap_exp",    int'(exp_a),    8'h25);
            chk("t4.gap_pulse",  int'(pulse_a),  0);
        end
        cycle(0, 1, 8'h25, "t4");
        chk("t4.resume_locked", int'(locked_a), 1);
        chk("t4.resume_cnt",    int'(cnt_a),    0);

        // Saturation of the narrow counter across repeated lock/break cycles.
        cycle(1, 0, 8'h00, "t5");
        pulses = 0;
        w = 8'h30;
        cycle(0, 1, w, "t5");
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 3; j++) begin
                w = nxt(w);
                cycle(0, 1, w, "t5");
            end
            chk("t5.locked_before", int'(locked_b), 1);
            w = nxt(w) ^ 8'h55;
            cycle(0, 1, w, "t5");
            if (pulse_b) pulses++;
            chk("t5.cnt_b", int'(cnt_b), exp5[k]);
            chk("t5.cnt_a", int'(cnt_a), k + 1);
        end
        chk("t5.pulses", pulses, 5);
        // A second break straight after the first lands in SYNC and stays silent.
        cycle(0, 1, 8'hC3, "t5b2b");
        chk("t5.b2b_pulse", int'(pulse_a), 0);
        chk("t5.b2b_cnt",   int'(cnt_a),   5);

        // Restart overrides a valid word, then an asynchronous clear mid-cycle.
        cycle(1, 0, 8'h00, "t6");
        lock_from(8'h40);
        cycle(0, 1, 8'h77, "t6");
        lock_from(8'h50);
        cycle(0, 1, 8'h77, "t6");
        lock_from(8'h60);
        chk("t6.cnt_pre", int'(cnt_a), 2);
        cycle(1, 1, 8'h99, "t6");
        chk("t6.rs_locked", int'(locked_a), 0);
        chk("t6.rs_cnt",    int'(cnt_a),    0);
        chk("t6.rs_exp",    int'(exp_a),    0);
        cycle(0, 1, 8'h9A, "t6");
        chk("t6.after_locked", int'(locked_a), 0);
        chk("t6.after_exp",    int'(exp_a),    8'h9B);
        cycle(0, 1, 8'h11, "t6");
        lock_from(8'h70);
        cycle(0, 1, 8'h01, "t6");
        #2;
        clear_n = 1'b0;
        #1;
        model_clear();
        chk("t6.clr_locked", int'(locked_a), 0);
        chk("t6.clr_pulse",  int'(pulse_a),  0);
        chk("t6.clr_cnt",    int'(cnt_a),    0);
        chk("t6.clr_exp",    int'(exp_a),    0);
        chk("t6.clr_cnt_b",  int'(cnt_b),    0);
        in_valid = 1'b0;
        #3;
        clear_n = 1'b1;

        // Random stream, mostly on-sequence to reach lock often.
        for (int n = 0; n < 3000; n++) begin
            bit r, v;
            logic [7:0] wr;
            r = ($urandom_range(0, 63) == 0);
            v = ($urandom_range(0, 3) != 0);
            wr = ($urandom_range(0, 9) < 8) ? m_exp : 8'($urandom_range(0, 255));
            if (m_run == 0) wr = 8'($urandom_range(0, 255));
            cycle(r, v, wr, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
